// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 1-word lines.
// Read hits complete in one cycle; misses and all writes use the main_memory handshake.
module dm_cache_ctrl #(
  parameter int unsigned AWIDTH  = 9,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] data_in,
  input  logic [DWIDTH-1:0] data_out,
  input  logic              ready_mem,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W = AWIDTH - INDEX_W;

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WAIT_RD, MEM_WR, MEM_WAIT_WR} state_t;

  state_t              state_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DWIDTH-1:0]   data_q [LINES];
  logic [DWIDTH-1:0]   rdata_q;
  logic                done_q, rd_mem_q, wr_mem_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]    hit_q, miss_q;

  logic [INDEX_W-1:0]  cpu_idx, mem_idx, line_idx_d;
  logic [TAG_W-1:0]    cpu_tag;
  logic                hit, accept, line_we_d, tag_we_d;
  logic [DWIDTH-1:0]   line_data_d;

  assign cpu_idx  = cpu_addr[INDEX_W-1:0];
  assign cpu_tag  = cpu_addr[AWIDTH-1:INDEX_W];
  assign mem_idx  = addr_q[INDEX_W-1:0];
  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign cpu_busy = (state_q != IDLE) || !ready_mem;
  assign accept   = (state_q == IDLE) && cpu_req && !cpu_busy;

  assign cpu_rdata  = rdata_q;
  assign cpu_done   = done_q;
  assign rd_mem     = rd_mem_q;
  assign wr_mem     = wr_mem_q;
  assign addr_mem   = addr_q;
  assign data_in    = wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Tag/data arrays carry no reset; only the valid bits are cleared.
  always_comb begin
    line_we_d   = 1'b0;
    tag_we_d    = 1'b0;
    line_idx_d  = cpu_idx;
    line_data_d = cpu_wdata;
    if (reset_n) begin
      if (accept && cpu_we && hit) begin
        line_we_d = 1'b1;
      end else if (state_q == MEM_WAIT_RD && ready_mem) begin
        line_we_d   = 1'b1;
        tag_we_d    = 1'b1;
        line_idx_d  = mem_idx;
        line_data_d = data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_we_d) data_q[line_idx_d] <= line_data_d;
    if (tag_we_d)  tag_q[line_idx_d]  <= addr_q[AWIDTH-1:INDEX_W];
  end

  // Memory strobes are raised on entry to MEM_RD/MEM_WR so they are high during
  // that state's cycle; the wait state then sees main_memory's ready response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= cpu_addr;
            if (cpu_we) begin
              wdata_q  <= cpu_wdata;
              wr_mem_q <= 1'b1;
              state_q  <= MEM_WR;
            end else if (hit) begin
              rdata_q <= data_q[cpu_idx];
              done_q  <= 1'b1;
              if (hit_q != '1) hit_q <= hit_q + 1'b1;
            end else begin
              rd_mem_q <= 1'b1;
              state_q  <= MEM_RD;
              if (miss_q != '1) miss_q <= miss_q + 1'b1;
            end
          end
        end
        MEM_RD: state_q <= MEM_WAIT_RD;
        MEM_WAIT_RD: begin
          if (ready_mem) begin
            rdata_q          <= data_out;
            valid_q[mem_idx] <= 1'b1;
            done_q           <= 1'b1;
            state_q          <= IDLE;
          end
        end
        MEM_WR: state_q <= MEM_WAIT_WR;
        MEM_WAIT_WR: begin
          if (ready_mem) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
